dadda_mul_sched: RTL and testbench

// - Shares one pipelined MBE/Dadda signed multiplier between N_REQ requesters.
// - Round-robin arbitration. Operand issue register drives the multiplier; a tag pipeline tracks in-flight products.
// - Returned products go through a credit-protected response FIFO, so downstream backpressure never loses a result.
// - Sits between the FP/ALU front-ends and the shared multiplier datapath.

---
 rtl/mod_dadda_mul_pkg.sv | 26 ++
 rtl/dadda_mul_sched_if.sv | 29 ++
 rtl/dadda_mul_sched_rr_arbiter.sv | 43 ++++
 rtl/dadda_mul_sched.sv | 99 +++++++++
 tb/tb_dadda_mul_sched.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_dadda_mul_pkg.sv
// Shared types and sizing for the multiplier scheduler: tag-pipe and response-FIFO entries.
package mod_dadda_mul_pkg;

  function automatic int id_width(int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int SCHED_N_REQ     = 4;
  localparam int SCHED_DATA_W    = 24;
  localparam int SCHED_MUL_LAT   = 2;
  localparam int SCHED_RSP_DEPTH = 4;
  localparam int SCHED_ID_W      = id_width(SCHED_N_REQ);

  typedef struct packed {
    logic                  valid;
    logic [SCHED_ID_W-1:0] id;
  } sched_tag_t;

  typedef struct packed {
    logic [SCHED_ID_W-1:0]     id;
    logic [2*SCHED_DATA_W-1:0] product;
  } rsp_entry_t;

endpackage

// File: rtl/dadda_mul_sched_if.sv
// Requester and response bus of the multiplier scheduler.
interface dadda_mul_sched_if
  import mod_dadda_mul_pkg::*;
#(
  parameter int N_REQ  = SCHED_N_REQ,
  parameter int DATA_W = SCHED_DATA_W,
  parameter int ID_W   = SCHED_ID_W
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid is not allowed to depend on ready, and payload is only meaningful while valid.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [2*DATA_W-1:0]     rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/dadda_mul_sched_rr_arbiter.sv
// Round-robin arbiter: highest priority goes to the index after the last grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [PW-1:0] grant_id
);
  // ptr_q is the index holding highest priority this cycle
  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = (int'(grant_id) == N - 1) ? '0 : grant_id + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dadda_mul_sched.sv
// Shares one pipelined signed multiplier between N_REQ requesters with a credit-protected
// response FIFO, so downstream stalls never drop a product.
module dadda_mul_sched
  import mod_dadda_mul_pkg::*;
#(
  parameter int N_REQ     = SCHED_N_REQ,
  parameter int DATA_W    = SCHED_DATA_W,
  parameter int MUL_LAT   = SCHED_MUL_LAT,
  parameter int RSP_DEPTH = SCHED_RSP_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  dadda_mul_sched_if.slave    bus,
  output logic                mul_valid,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                busy
);
  localparam int ID_W = id_width(N_REQ);
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [N_REQ-1:0]  grant, ready;
  logic [ID_W-1:0]   grant_id, iss_id_q;
  logic              can_issue, issue, push, pop;
  logic [CW-1:0]     inflight_q, inflight_d, cnt_q, cnt_d;
  logic [CW:0]       used;
  logic              mul_valid_q;
  logic [DATA_W-1:0] mul_a_q, mul_b_q, sel_a, sel_b;
  logic [PW-1:0]     wr_q, rd_q;
  sched_tag_t        tag_q [MUL_LAT];
  rsp_entry_t        mem_q [RSP_DEPTH];

  rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (issue),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Credit covers every product issued but not yet popped, so a push always finds room.
  assign used      = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign can_issue = used < (CW + 1)'(RSP_DEPTH);
  assign ready     = grant & {N_REQ{can_issue & rst_n}};
  assign issue     = |(bus.req_valid & ready);
  assign push      = tag_q[MUL_LAT-1].valid;
  assign pop       = (cnt_q != '0) & bus.rsp_ready;

  always_comb begin
    sel_a      = bus.req_a[int'(grant_id)*DATA_W +: DATA_W];
    sel_b      = bus.req_b[int'(grant_id)*DATA_W +: DATA_W];
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      iss_id_q    <= '0;
      inflight_q  <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mul_valid_q <= issue;
      if (issue) begin
        mul_a_q  <= sel_a;
        mul_b_q  <= sel_b;
        iss_id_q <= grant_id;
      end
      // Stage 0 lines up with mul_valid; the last stage lines up with mul_p.
      tag_q[0] <= {mul_valid_q, iss_id_q};
      for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (push) begin
        mem_q[wr_q] <= {tag_q[MUL_LAT-1].id, mul_p};
        wr_q        <= (wr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (pop) rd_q <= (rd_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_q + PW'(1);
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_id    = mem_q[rd_q].id;
  assign bus.rsp_p     = mem_q[rd_q].product;
  assign mul_valid     = mul_valid_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign busy          = (inflight_q != '0) | (cnt_q != '0);
endmodule

// File: tb/tb_dadda_mul_sched.sv
// Bench for dadda_mul_sched: directed vectors, corner sequences and a random run against a queue model.
module tb_dadda_mul_sched;
  import mod_dadda_mul_pkg::*;

  localparam int N_REQ     = SCHED_N_REQ;
  localparam int DATA_W    = SCHED_DATA_W;
  localparam int MUL_LAT   = SCHED_MUL_LAT;
  localparam int RSP_DEPTH = SCHED_RSP_DEPTH;
  localparam int ID_W      = SCHED_ID_W;
  localparam int EW        = ID_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dadda_mul_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  logic                mul_valid, busy;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [2*DATA_W-1:0] mul_p;

  dadda_mul_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  function automatic logic [2*DATA_W-1:0] ref_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (2*DATA_W)'(sa * sb);
  endfunction

  // multiplier model: MUL_LAT register stages of a*b
  logic [2*DATA_W-1:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= ref_mul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[MUL_LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds every accepted request not yet popped: its size is the credit in use.
  logic [EW-1:0]     exp_q[$];
  int                rdy_q[$];
  int                rr_next = 0;
  logic              prev_iss = 1'b0;
  logic [DATA_W-1:0] last_a = '0, last_b = '0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0]    head;
    logic [N_REQ-1:0] exp_ready;
    logic             exp_rv;
    int               g, idx;
    if (!rst_n) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_p", bus.rsp_p, 0);
      check("rst_mul_valid", mul_valid, 0);
      check("rst_mul_ab", {mul_a, mul_b}, 0);
      check("rst_busy", busy, 0);
      exp_q.delete();
      rdy_q.delete();
      rr_next  = 0;
      prev_iss = 1'b0;
      last_a   = '0;
      last_b   = '0;
    end else begin
      exp_rv = (exp_q.size() != 0) && (cyc >= rdy_q[0]);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        head = exp_q[0];
        check("rsp_id", bus.rsp_id, head[EW-1 -: ID_W]);
        check("rsp_p", bus.rsp_p, head[2*DATA_W-1:0]);
      end
      check("busy", busy, exp_q.size() != 0);
      check("mul_valid", mul_valid, prev_iss);
      check("mul_a", mul_a, last_a);
      check("mul_b", mul_b, last_b);
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (rr_next + k) % N_REQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
      exp_ready = '0;
      if (g >= 0 && exp_q.size() < RSP_DEPTH) exp_ready[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_ready);
      if (exp_rv && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      prev_iss = (exp_ready != '0);
      if (prev_iss) begin
        last_a = bus.req_a[g*DATA_W +: DATA_W];
        last_b = bus.req_b[g*DATA_W +: DATA_W];
        exp_q.push_back({ID_W'(g), ref_mul(last_a, last_b)});
        rdy_q.push_back(cyc + 2 + MUL_LAT);
        rr_next = (g + 1) % N_REQ;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    n = 0;
    #1;
    while (busy && n < 50) begin
      tick();
      #1;
      n++;
    end
    check(name, busy, 0);
  endtask

  function automatic logic [DATA_W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(DATA_W-1){1'b0}}};
      1:       return {1'b0, {(DATA_W-1){1'b1}}};
      2:       return '0;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  typedef struct {
    int                  idx;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [2*DATA_W-1:0] p;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, n, acc;
    vecs[0] = '{0, 24'h000003, 24'hFFFFFB, 48'hFFFF_FFFF_FFF1};
    vecs[1] = '{1, 24'h800000, 24'h800000, 48'h4000_0000_0000};
    vecs[2] = '{2, 24'h7FFFFF, 24'hFFFFFF, 48'hFFFF_FF80_0001};
    vecs[3] = '{3, 24'h000000, 24'h123456, 48'h0000_0000_0000};
    vecs[4] = '{1, 24'hFFFFFF, 24'hFFFFFF, 48'h0000_0000_0001};
    vecs[5] = '{2, 24'h7FFFFF, 24'h7FFFFF, 48'h3FFF_FF00_0001};
    vecs[6] = '{0, 24'h800000, 24'h7FFFFF, 48'hC000_0080_0000};

    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #12;
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // table: single requests, latency and product
    foreach (vecs[v]) begin
      bus.req_valid = '0;
      bus.req_valid[vecs[v].idx] = 1'b1;
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b);
      tick();
      bus.req_valid = '0;
      #1;
      check("vec_mul_valid", mul_valid, 1);
      check("vec_mul_a", mul_a, vecs[v].a);
      check("vec_mul_b", mul_b, vecs[v].b);
      lat = 0;
      while (!bus.rsp_valid && lat < 10) begin
        tick();
        #1;
        lat++;
      end
      check("vec_latency", lat, MUL_LAT + 1);
      check("vec_rsp_id", bus.rsp_id, vecs[v].idx);
      check("vec_rsp_p", bus.rsp_p, vecs[v].p);
      tick();
      #1;
      check("vec_busy_after_pop", busy, 0);
      check("vec_rsp_valid_after_pop", bus.rsp_valid, 0);
    end

    // all requesters valid: responses come back 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, DATA_W'(i + 1), DATA_W'(3 * i + 7));
    bus.req_valid = '1;
    n = 0;
    for (int c = 0; c < 80 && n < 12; c++) begin
      tick();
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rr_seq_id", bus.rsp_id, n % N_REQ);
        n++;
      end
    end
    check("rr_seq_count", n, 12);
    drain("rr_seq_drain");

    // stalled consumer: credit stops issue after RSP_DEPTH accepts
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if ((bus.req_valid & bus.req_ready) != '0) acc++;
      tick();
    end
    #1;
    check("stall_accepts", acc, RSP_DEPTH);
    check("stall_req_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    #1;
    check("stall_ready_same_cycle", bus.req_ready, 0);
    tick();
    #1;
    check("stall_resume", (bus.req_ready != '0), 1);
    drain("stall_drain");

    // reset with two products in flight and one buffered
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_valid[0] = 1'b1;
    set_req(0, 24'h000005, 24'h000007);
    tick();
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    check("prereset_busy", busy, 1);
    check("prereset_rsp_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", bus.rsp_valid, 0);
    check("async_rst_rsp_p", bus.rsp_p, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_mul_valid", mul_valid, 0);
    check("async_rst_mul_a", mul_a, 0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      if (bus.rsp_valid) n++;
    end
    check("no_stale_rsp", n, 0);
    bus.req_valid = '1;
    #1;
    check("rr_restart", bus.req_ready, 1);
    tick();
    drain("reset_drain");

    // random traffic against the model
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) set_req(i, rand_op(), rand_op());
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain("random_drain");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
